// File: rtl/spi_frame_sequencer.sv
// rtl/spi_frame_sequencer.sv - command FIFO and req/ack sequencer feeding a 16-bit SPI frame driver
module spi_frame_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024,
    parameter int GAP        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [15:0]                   cmd_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [15:0]                   rsp_data,
    output logic                          rsp_err,
    output logic                          spi_req,
    output logic [15:0]                   spi_din,
    input  logic                          spi_ack,
    input  logic [15:0]                   spi_dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    state_t          state, state_next;

    logic [15:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic            push, pop;

    logic [TW-1:0]   tcnt, tcnt_next, tcnt_inc;
    logic [GW-1:0]   gcnt, gcnt_next;
    logic [15:0]     rsp_data_next;
    logic            rsp_err_next;

    assign cmd_ready  = (level != LW'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_level = level;
    assign busy       = (state != S_IDLE) || (level != '0);
    // Count including the current WAIT cycle, so the abort lands TIMEOUT cycles after REQ.
    assign tcnt_inc   = tcnt + TW'(1);

    // Command storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // State, counters, frame word and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tcnt     <= '0;
            gcnt     <= '0;
            spi_din  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state    <= state_next;
            tcnt     <= tcnt_next;
            gcnt     <= gcnt_next;
            rsp_data <= rsp_data_next;
            rsp_err  <= rsp_err_next;
            if (pop) begin
                spi_din <= mem[rd_ptr];
            end
        end
    end

    // Next-state, counter and output decode; ack is only honoured in WAIT and beats the timeout.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        spi_req       = 1'b0;
        rsp_valid     = 1'b0;
        tcnt_next     = tcnt;
        gcnt_next     = gcnt;
        rsp_data_next = rsp_data;
        rsp_err_next  = rsp_err;
        case (state)
            S_IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                spi_req    = 1'b1;
                tcnt_next  = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                tcnt_next = tcnt_inc;
                if (spi_ack) begin
                    rsp_data_next = spi_dout;
                    rsp_err_next  = 1'b0;
                    state_next    = S_RESP;
                end else if (tcnt_inc == TW'(TIMEOUT - 1)) begin
                    rsp_data_next = 16'h0000;
                    rsp_err_next  = 1'b1;
                    state_next    = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                gcnt_next = '0;
                if (rsp_ready) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gcnt == GW'(GAP - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    gcnt_next = gcnt + GW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb/tb_spi_frame_sequencer.sv - self-checking bench for spi_frame_sequencer
module tb_spi_frame_sequencer;

    localparam int DEPTH = 4;
    localparam int TO    = 32;
    localparam int GP    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        spi_req;
    logic [15:0] spi_din;
    logic        spi_ack;
    logic [15:0] spi_dout;
    logic        busy;
    logic [2:0]  fifo_level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spi_frame_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TO),
        .GAP       (GP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .spi_req   (spi_req),
        .spi_din   (spi_din),
        .spi_ack   (spi_ack),
        .spi_dout  (spi_dout),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    typedef struct {
        logic [15:0] cmd;
        int          dly;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] w[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] nibrev(input logic [15:0] d);
        return {d[3:0], d[7:4], d[11:8], d[15:12]};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"},  cmd_ready,  1);
        check({tag, "_fifo_level"}, fifo_level, 0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_rsp_valid"},  rsp_valid,  0);
        check({tag, "_rsp_data"},   rsp_data,   0);
        check({tag, "_rsp_err"},    rsp_err,    0);
        check({tag, "_spi_req"},    spi_req,    0);
        check({tag, "_spi_din"},    spi_din,    0);
    endtask

    task automatic run_frame(input vec_t v);
        int lat;
        int n;
        int bad;
        cmd_valid = 1'b1;
        cmd_data  = v.cmd;
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("level_after_push", fifo_level, 1);
        tick();
        check("req_pulse", spi_req, 1);
        check("spi_din", spi_din, v.cmd);
        lat = -1;
        bad = 0;
        for (int k = 1; k <= TO + 4; k++) begin
            tick();
            spi_ack = 1'b0;
            if (spi_req) bad++;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            if (k == v.dly) begin
                spi_ack  = 1'b1;
                spi_dout = nibrev(v.cmd);
            end
        end
        check("rsp_latency", lat, v.exp_lat);
        check("rsp_data", rsp_data, v.exp_data);
        check("rsp_err", rsp_err, v.exp_err);
        check("single_req", bad, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        spi_ack   = 1'b1;
        spi_dout  = 16'hDEAD;
        tick();
        spi_ack = 1'b0;
        n   = 0;
        bad = 0;
        while (busy && n < 40) begin
            if (rsp_valid || spi_req) bad++;
            tick();
            n++;
        end
        check("gap_len", n, GP - 1);
        check("spurious_ack_ignored", bad, 0);
    endtask

    initial begin
        int bad;
        int n;
        int prev;

        vecs[0] = '{16'hA5C3, 3,  16'h3C5A, 1'b0, 4};
        vecs[1] = '{16'h1234, 1,  16'h4321, 1'b0, 2};
        vecs[2] = '{16'hFFFF, 0,  16'h0000, 1'b1, TO};
        vecs[3] = '{16'h0F0F, TO - 1, 16'hF0F0, 1'b0, TO};
        vecs[4] = '{16'h8001, 10, 16'h1008, 1'b0, 11};
        w[0] = 16'h1357;
        w[1] = 16'h2468;
        w[2] = 16'hBEEF;
        w[3] = 16'h0A0B;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0000;
        rsp_ready = 1'b0;
        spi_ack   = 1'b0;
        spi_dout  = 16'h0000;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
        end

        // Backpressure in RESP while the FIFO fills behind it.
        cmd_valid = 1'b1;
        cmd_data  = 16'hC001;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("bp_req", spi_req, 1);
        tick();
        tick();
        spi_ack  = 1'b1;
        spi_dout = nibrev(16'hC001);
        tick();
        spi_ack = 1'b0;
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_data", rsp_data, 16'h100C);
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = w[i];
            tick();
        end
        cmd_valid = 1'b0;
        check("fill_level", fifo_level, 4);
        check("fill_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_data  = 16'h5555;
        bad = 0;
        for (int k = 0; k < 95; k++) begin
            if (!rsp_valid || rsp_data !== 16'h100C || rsp_err !== 1'b0 || spi_req
                || fifo_level != 3'd4 || cmd_ready) bad++;
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_hold_stable", bad, 0);
        check("fifth_held_off", fifo_level, 4);

        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!spi_req && n < 60) begin
                tick();
                n++;
            end
            check("drain_req_seen", spi_req, 1);
            check("drain_spi_din", spi_din, w[i]);
            if (i > 0) check("req_spacing", cyc - prev, GP + 5);
            prev = cyc;
            tick();
            tick();
            spi_ack  = 1'b1;
            spi_dout = nibrev(w[i]);
            tick();
            spi_ack = 1'b0;
            check("drain_rsp_valid", rsp_valid, 1);
            check("drain_rsp_data", rsp_data, nibrev(w[i]));
            check("drain_rsp_err", rsp_err, 0);
        end
        tick();
        rsp_ready = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("drain_idle", busy, 0);

        // Reset in WAIT with two words queued.
        cmd_valid = 1'b1;
        cmd_data  = 16'h7001;
        tick();
        cmd_data = 16'h7002;
        tick();
        cmd_data = 16'h7003;
        tick();
        cmd_valid = 1'b0;
        check("rst_pre_level", fifo_level, 2);
        check("rst_pre_din", spi_din, 16'h7001);
        tick();
        rst = 1'b1;
        tick();
        check_reset_values("mid_reset");
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rsp_valid || spi_req || busy) bad++;
        end
        check("no_rsp_after_reset", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
